// File: rtl/screen_drawer.sv
// Sweeps the 160x120 frame for the requested SCREEN image through a synchronous ROM into the VGA plot port.
// Optional transparency skipping is compiled in with `define SCREEN_DRAWER_TRANSPARENT_EN.
module screen_drawer #(
   parameter int WIDTH       = 160,
   parameter int HEIGHT      = 120,
   parameter int COLOUR_W    = 3,
   parameter int TRANSPARENT = 0
) (
   input  logic                CLOCK_50,
   input  logic                RESETN,
   input  logic [1:0]          SCREEN,
   output logic [16:0]         ROM_ADDR,
   input  logic [COLOUR_W-1:0] ROM_DATA,
   output logic [7:0]          VGA_X,
   output logic [6:0]          VGA_Y,
   output logic [COLOUR_W-1:0] VGA_COLOUR,
   output logic                VGA_PLOT,
   output logic                DRAW_BUSY,
   output logic                DRAW_DONE
);

   localparam logic [7:0]          X_LAST   = 8'(WIDTH - 1);
   localparam logic [6:0]          Y_LAST   = 7'(HEIGHT - 1);
   localparam logic [COLOUR_W-1:0] TRANSP_C = COLOUR_W'(TRANSPARENT);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SWEEP,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t     state, state_n;
   logic       start, abort, load;
   logic       drain_cnt;
   logic [1:0] cur_scr, drawn_scr;
   logic       drawn_valid;

   logic [7:0] x_p0, x_p1;
   logic [6:0] y_p0, y_p1;
   logic       vld_p0, vld_p1;
   logic       last_p0;
   logic       keep_p1;

   assign last_p0   = (x_p0 == X_LAST) && (y_p0 == Y_LAST);
   assign load      = start || abort;
   assign DRAW_BUSY = (state == S_SWEEP) || (state == S_DRAIN);
   assign DRAW_DONE = (state == S_DONE);

`ifdef SCREEN_DRAWER_TRANSPARENT_EN
   function automatic logic pix_keep(input logic [COLOUR_W-1:0] c);
      return c != TRANSP_C;
   endfunction

   assign keep_p1 = pix_keep(ROM_DATA);
`else
   logic unused_transp;

   assign unused_transp = ^TRANSP_C;
   assign keep_p1       = 1'b1;
`endif

   // A SCREEN change while sweeping or draining restarts the sweep from the new image.
   always_comb begin
      state_n = state;
      start   = 1'b0;
      abort   = 1'b0;
      case (state)
         S_IDLE: begin
            if (!drawn_valid || (SCREEN != drawn_scr)) begin
               start   = 1'b1;
               state_n = S_SWEEP;
            end
         end
         S_SWEEP: begin
            if (SCREEN != cur_scr) begin
               abort = 1'b1;
            end else if (last_p0) begin
               state_n = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (SCREEN != cur_scr) begin
               abort   = 1'b1;
               state_n = S_SWEEP;
            end else if (drain_cnt) begin
               state_n = S_DONE;
            end
         end
         S_DONE:  state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge CLOCK_50 or negedge RESETN) begin
      if (!RESETN) begin
         state       <= S_IDLE;
         drain_cnt   <= 1'b0;
         cur_scr     <= 2'b00;
         drawn_scr   <= 2'b00;
         drawn_valid <= 1'b0;
      end else begin
         state     <= state_n;
         drain_cnt <= (state == S_DRAIN) ? ~drain_cnt : 1'b0;
         if (load) begin
            cur_scr <= SCREEN;
         end
         if (state == S_DONE) begin
            drawn_scr   <= cur_scr;
            drawn_valid <= 1'b1;
         end
      end
   end

   // Stage p0: ROM address and its pixel coordinates; idx steps by one per pixel.
   always_ff @(posedge CLOCK_50 or negedge RESETN) begin
      if (!RESETN) begin
         ROM_ADDR <= '0;
         x_p0     <= '0;
         y_p0     <= '0;
         vld_p0   <= 1'b0;
      end else if (load) begin
         ROM_ADDR <= {SCREEN, 15'd0};
         x_p0     <= '0;
         y_p0     <= '0;
         vld_p0   <= 1'b1;
      end else if ((state == S_SWEEP) && !last_p0) begin
         ROM_ADDR[14:0] <= ROM_ADDR[14:0] + 15'd1;
         vld_p0         <= 1'b1;
         if (x_p0 == X_LAST) begin
            x_p0 <= '0;
            y_p0 <= y_p0 + 7'd1;
         end else begin
            x_p0 <= x_p0 + 8'd1;
         end
      end else begin
         vld_p0 <= 1'b0;
      end
   end

   // Stage p1: coordinates aligned with ROM_DATA arriving from the ROM.
   always_ff @(posedge CLOCK_50) begin
      x_p1 <= x_p0;
      y_p1 <= y_p0;
   end

   always_ff @(posedge CLOCK_50 or negedge RESETN) begin
      if (!RESETN) begin
         vld_p1 <= 1'b0;
      end else begin
         vld_p1 <= vld_p0 && !abort;
      end
   end

   // Stage p2: registered plot outputs.
   always_ff @(posedge CLOCK_50 or negedge RESETN) begin
      if (!RESETN) begin
         VGA_X      <= '0;
         VGA_Y      <= '0;
         VGA_COLOUR <= '0;
         VGA_PLOT   <= 1'b0;
      end else begin
         VGA_X      <= x_p1;
         VGA_Y      <= y_p1;
         VGA_COLOUR <= ROM_DATA;
         VGA_PLOT   <= vld_p1 && !abort && keep_p1;
      end
   end

endmodule

// File: tb/tb_screen_drawer.sv
// Directed bench for screen_drawer: full frames, restart after reset, mid-sweep abort, idle hold.
module tb_screen_drawer;

   localparam int W     = 160;
   localparam int H     = 120;
   localparam int NPIX  = W * H;
`ifdef SCREEN_DRAWER_TRANSPARENT_EN
   localparam int STEP      = 2;
   localparam int FIRST_IDX = 1;
`else
   localparam int STEP      = 1;
   localparam int FIRST_IDX = 0;
`endif
   localparam int PLOTS      = NPIX / STEP;
   localparam int FIRST_LAT  = 3 + FIRST_IDX;
   localparam int ABORT_AT   = 5000;
   localparam int PRE_ABORT  = (ABORT_AT - 2 - FIRST_IDX) / STEP + 1;

   logic        CLOCK_50 = 1'b0;
   logic        RESETN;
   logic [1:0]  SCREEN;
   logic [16:0] ROM_ADDR;
   logic [2:0]  ROM_DATA = 3'd0;
   logic [7:0]  VGA_X;
   logic [6:0]  VGA_Y;
   logic [2:0]  VGA_COLOUR;
   logic        VGA_PLOT;
   logic        DRAW_BUSY;
   logic        DRAW_DONE;

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;
   int plot_cnt, done_cnt, bad_pix, last_idx;
   int first_cyc, done_cyc, rel_cyc, pidx;

   screen_drawer dut (
      .CLOCK_50   (CLOCK_50),
      .RESETN     (RESETN),
      .SCREEN     (SCREEN),
      .ROM_ADDR   (ROM_ADDR),
      .ROM_DATA   (ROM_DATA),
      .VGA_X      (VGA_X),
      .VGA_Y      (VGA_Y),
      .VGA_COLOUR (VGA_COLOUR),
      .VGA_PLOT   (VGA_PLOT),
      .DRAW_BUSY  (DRAW_BUSY),
      .DRAW_DONE  (DRAW_DONE)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   function automatic logic [2:0] rom_f(input int idx);
`ifdef SCREEN_DRAWER_TRANSPARENT_EN
      return (idx % 2 == 1) ? 3'(idx % 8) : 3'd0;
`else
      return 3'(idx % 8);
`endif
   endfunction

   always @(posedge CLOCK_50) begin
      ROM_DATA <= rom_f(int'(ROM_ADDR[14:0]));
      cyc      <= cyc + 1;
   end

   // Every plot must be the next expected raster pixel with the ROM colour for its index.
   always @(negedge CLOCK_50) begin
      if (VGA_PLOT) begin
         pidx = int'(VGA_Y) * W + int'(VGA_X);
         if ((pidx != last_idx + STEP) || (VGA_COLOUR != rom_f(pidx)))
            bad_pix++;
         if (plot_cnt == 0)
            first_cyc = cyc;
         last_idx = pidx;
         plot_cnt++;
      end
      if (DRAW_DONE) begin
         done_cnt++;
         done_cyc = cyc;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic clear_stats();
      plot_cnt  = 0;
      done_cnt  = 0;
      bad_pix   = 0;
      last_idx  = -1;
      first_cyc = 0;
      done_cyc  = 0;
      rel_cyc   = cyc;
   endtask

   task automatic wait_done(input int budget);
      int n = 0;
      while (done_cnt == 0 && n < budget) begin
         @(negedge CLOCK_50);
         n++;
      end
      #1;
      check("done_seen", 32'(done_cnt > 0), 32'd1);
   endtask

   task automatic wait_addr(input int target, input int budget);
      int n = 0;
      while (int'(ROM_ADDR[14:0]) != target && n < budget) begin
         @(negedge CLOCK_50);
         n++;
      end
      #1;
      check("addr_reached", 32'(ROM_ADDR[14:0]), 32'(target));
   endtask

   task automatic check_frame(input string tag);
      check({tag, "_plots"}, 32'(plot_cnt), 32'(PLOTS));
      check({tag, "_order"}, 32'(bad_pix), 32'd0);
      check({tag, "_last"}, 32'(last_idx), 32'(NPIX - 1));
      check({tag, "_first_lat"}, 32'(first_cyc - rel_cyc), 32'(FIRST_LAT));
      check({tag, "_done_lat"}, 32'(done_cyc - rel_cyc), 32'(NPIX + 3));
      check({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
   endtask

   initial begin
      #1_500_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      RESETN = 1'b0;
      SCREEN = 2'b00;
      clear_stats();
      repeat (3) @(posedge CLOCK_50);
      #1;
      check("rst_addr", 32'(ROM_ADDR), 32'd0);
      check("rst_plot", 32'(VGA_PLOT), 32'd0);
      check("rst_busy", 32'(DRAW_BUSY), 32'd0);
      check("rst_done", 32'(DRAW_DONE), 32'd0);
      check("rst_xyc", 32'({VGA_X, VGA_Y, VGA_COLOUR}), 32'd0);

      // Title frame straight after reset release.
      RESETN = 1'b1;
      clear_stats();
      @(posedge CLOCK_50);
      #1;
      check("a_busy", 32'(DRAW_BUSY), 32'd1);
      check("a_addr0", 32'(ROM_ADDR), 32'h00000);
      wait_done(NPIX + 100);
      check_frame("a");
      @(posedge CLOCK_50);
      #1;
      check("a_done_pulse", 32'(DRAW_DONE), 32'd0);
      check("a_idle_busy", 32'(DRAW_BUSY), 32'd0);

      // Background requested, then reset pulsed mid-sweep.
      SCREEN = 2'b01;
      clear_stats();
      @(posedge CLOCK_50);
      #1;
      check("b_addr0", 32'(ROM_ADDR), 32'h08000);
      check("b_busy", 32'(DRAW_BUSY), 32'd1);
      repeat (1000) @(posedge CLOCK_50);
      #3;
      RESETN = 1'b0;
      #1;
      check("b_arst_addr", 32'(ROM_ADDR), 32'd0);
      check("b_arst_plot", 32'(VGA_PLOT), 32'd0);
      check("b_arst_busy", 32'(DRAW_BUSY), 32'd0);
      check("b_arst_xy", 32'({VGA_X, VGA_Y}), 32'd0);
      repeat (2) @(posedge CLOCK_50);
      #1;
      RESETN = 1'b1;
      clear_stats();
      @(posedge CLOCK_50);
      #1;
      check("b_restart_addr", 32'(ROM_ADDR), 32'h08000);
      wait_addr(ABORT_AT, ABORT_AT + 100);
      check("b_pre_plots", 32'(plot_cnt), 32'(PRE_ABORT));
      check("b_pre_order", 32'(bad_pix), 32'd0);
      check("b_restart_lat", 32'(first_cyc - rel_cyc), 32'(FIRST_LAT));
      check("b_no_done", 32'(done_cnt), 32'd0);

      // Win screen requested mid-sweep: abort and restart.
      SCREEN = 2'b10;
      clear_stats();
      @(posedge CLOCK_50);
      #1;
      check("c_addr0", 32'(ROM_ADDR), 32'h10000);
      check("c_busy", 32'(DRAW_BUSY), 32'd1);
      repeat (2) @(negedge CLOCK_50);
      #1;
      check("c_gap", 32'(plot_cnt), 32'd0);
      wait_done(NPIX + 100);
      check_frame("c");

      // Hold the drawn screen: nothing further happens.
      @(posedge CLOCK_50);
      #1;
      clear_stats();
      repeat (10000) @(posedge CLOCK_50);
      #1;
      check("d_plots", 32'(plot_cnt), 32'd0);
      check("d_done", 32'(done_cnt), 32'd0);
      check("d_busy", 32'(DRAW_BUSY), 32'd0);
      check("d_addr_hold", 32'(ROM_ADDR), 32'h14AFF);

      // Lose screen starts its own sweep.
      SCREEN = 2'b11;
      @(posedge CLOCK_50);
      #1;
      check("e_addr0", 32'(ROM_ADDR), 32'h18000);
      check("e_busy", 32'(DRAW_BUSY), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
